// File: rtl/int_acc_seq.sv
// int_acc_seq: sequential 32-bit reduction controller that feeds an
// external integer adder one term per FETCH/ADD/WAIT round.
module int_acc_seq #(
    parameter int LEN_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [LEN_W-1:0] i_len,
    input  logic [31:0]      i_init,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [31:0]      i_in_data,
    output logic [31:0]      o_add_a,
    output logic [31:0]      o_add_b,
    output logic             o_add_op,
    output logic             o_add_ce,
    input  logic [31:0]      i_add_dout,
    input  logic             i_add_done,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [31:0]      o_out_data,
    output logic             o_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ADD,
        S_WAIT,
        S_OUT
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [31:0]      r_acc;
    logic [31:0]      r_term;
    logic [LEN_W-1:0] r_cnt;
    logic [LEN_W-1:0] r_target;
    logic [LEN_W-1:0] w_cnt_inc;
    logic             w_last;
    logic             w_load;
    logic             w_take_term;
    logic             w_take_sum;

    assign w_cnt_inc   = r_cnt + LEN_W'(1);
    assign w_last      = (w_cnt_inc == r_target);
    assign w_load      = (r_state == S_IDLE) && i_start;
    assign w_take_term = (r_state == S_FETCH) && i_in_valid;
    assign w_take_sum  = (r_state == S_WAIT) && i_add_done;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        o_in_ready  = 1'b0;
        o_add_ce    = 1'b0;
        o_out_valid = 1'b0;
        o_busy      = 1'b1;
        unique case (r_state)
            S_IDLE: begin
                o_busy = 1'b0;
                if (i_start) begin
                    w_next = (i_len == '0) ? S_OUT : S_FETCH;
                end
            end
            S_FETCH: begin
                o_in_ready = 1'b1;
                if (i_in_valid) begin
                    w_next = S_ADD;
                end
            end
            S_ADD: begin
                o_add_ce = 1'b1;
                w_next   = S_WAIT;
            end
            S_WAIT: begin
                if (i_add_done) begin
                    w_next = w_last ? S_OUT : S_FETCH;
                end
            end
            S_OUT: begin
                o_out_valid = 1'b1;
                if (i_out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Operands stay registered from ADD through WAIT so the adder's
    // combinational result is settled when done arrives.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_acc    <= '0;
            r_term   <= '0;
            r_cnt    <= '0;
            r_target <= '0;
        end else begin
            if (w_load) begin
                r_target <= i_len;
                r_acc    <= i_init;
                r_cnt    <= '0;
            end
            if (w_take_term) begin
                r_term <= i_in_data;
            end
            if (w_take_sum) begin
                r_acc <= i_add_dout;
                r_cnt <= w_cnt_inc;
            end
        end
    end

    assign o_add_a    = r_acc;
    assign o_add_b    = r_term;
    assign o_add_op   = 1'b1;
    assign o_out_data = r_acc;

endmodule

// File: tb/tb_int_acc_seq.sv
// tb_int_acc_seq: randomized and directed reductions checked against a
// sum-of-terms model, with a one-cycle adder model closing the loop.
module tb_int_acc_seq;

    localparam int LEN_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] len;
    logic [31:0]      init;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data;
    logic [31:0]      add_a;
    logic [31:0]      add_b;
    logic             add_op;
    logic             add_ce;
    logic [31:0]      add_dout;
    logic             add_done;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic             busy;
    logic             done_r = 1'b0;
    logic             spur;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    int_acc_seq #(.LEN_W(LEN_W)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (start),
        .i_len      (len),
        .i_init     (init),
        .i_in_valid (in_valid),
        .o_in_ready (in_ready),
        .i_in_data  (in_data),
        .o_add_a    (add_a),
        .o_add_b    (add_b),
        .o_add_op   (add_op),
        .o_add_ce   (add_ce),
        .i_add_dout (add_dout),
        .i_add_done (add_done),
        .o_out_valid(out_valid),
        .i_out_ready(out_ready),
        .o_out_data (out_data),
        .o_busy     (busy)
    );

    // adder wrapper: combinational sum, done one cycle after ce
    always @(posedge clk) done_r <= rst ? 1'b0 : add_ce;
    assign add_dout = add_a + add_b;
    assign add_done = done_r | spur;

    logic [31:0] m_init;
    logic [31:0] m_final;
    logic [31:0] m_terms [256];
    logic [31:0] ce_a [256];
    int          m_len      = 0;
    int          m_epoch    = 0;
    int          seen_epoch = 0;
    int          m_k        = 0;
    logic [31:0] m_part     = 0;
    logic        prev_ce    = 0;
    logic        prev_v     = 0;
    logic        prev_rdy   = 0;
    logic [31:0] prev_d     = 0;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    function automatic int pick(input int p);
        return (p < 0) ? int'($urandom_range(0, 3)) : p;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            prev_ce  = 1'b0;
            prev_v   = 1'b0;
            prev_rdy = 1'b0;
        end else begin
            if (seen_epoch != m_epoch) begin
                seen_epoch = m_epoch;
                m_part     = m_init;
                m_k        = 0;
            end
            chk("add_op", 32'(add_op), 32'd1);
            chk("ce_back_to_back", 32'(add_ce & prev_ce), 32'd0);
            chk("ready_valid_overlap", 32'(in_ready & out_valid), 32'd0);
            if (add_ce) begin
                if (m_k < m_len) begin
                    chk("add_a", add_a, m_part);
                    chk("add_b", add_b, m_terms[m_k]);
                    ce_a[m_k] = add_a;
                    m_part    = m_part + m_terms[m_k];
                end
                m_k++;
            end
            if (out_valid) chk("out_data", out_data, m_final);
            if (prev_v && !prev_rdy) begin
                chk("out_hold_valid", 32'(out_valid), 32'd1);
                chk("out_hold_data", out_data, prev_d);
            end
            prev_ce  = add_ce;
            prev_v   = out_valid;
            prev_rdy = out_ready;
            prev_d   = out_data;
        end
    end

    // Entered and left at posedge+1 of an IDLE cycle; terms preloaded in m_terms.
    task automatic reduce(input logic [31:0] ini, input int n, input int gap,
                          input int hold, input int exp_rise, input int poke,
                          input bit do_spur, output logic [31:0] got);
        logic [31:0] sum;
        int          k;
        int          g;
        int          h;
        int          rise;
        int          nrdy;
        bit          fin;
        bit          vin;
        bit          vout;
        sum = ini;
        for (int i = 0; i < n; i++) sum = sum + m_terms[i];
        m_init  = ini;
        m_final = sum;
        m_len   = n;
        m_epoch++;
        start = 1'b1;
        len   = LEN_W'(n);
        init  = ini;
        k     = 0;
        g     = pick(gap);
        h     = pick(hold);
        rise  = -1;
        nrdy  = 0;
        fin   = 1'b0;
        got   = 32'hx;
        for (int c = 0; c < 5000 && !fin; c++) begin
            vin  = in_ready;
            vout = out_valid;
            if (c == 1) chk("busy_run", 32'(busy), 32'd1);
            if (c == poke) begin
                start = 1'b1;
                len   = 8'd5;
                init  = 32'hDEAD_BEEF;
            end else if (c >= 1) begin
                start = 1'b0;
                len   = LEN_W'($urandom);
                init  = $urandom;
            end
            spur = do_spur && vin;
            if (vin) nrdy++;
            if (vout && rise < 0) rise = c;
            if (k < n) begin
                if (g > 0) begin
                    in_valid = 1'b0;
                    in_data  = $urandom;
                    if (vin) g--;
                end else begin
                    in_valid = 1'b1;
                    in_data  = m_terms[k];
                    if (vin) begin
                        k++;
                        g = pick(gap);
                    end
                end
            end else begin
                in_valid = 1'($urandom_range(0, 1));
                in_data  = $urandom;
            end
            if (vout) begin
                if (h > 0) begin
                    out_ready = 1'b0;
                    h--;
                end else begin
                    out_ready = 1'b1;
                    got       = out_data;
                    fin       = 1'b1;
                end
            end else begin
                out_ready = 1'($urandom_range(0, 1));
            end
            @(posedge clk);
            #1;
        end
        spur      = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("completed", 32'(fin), 32'd1);
        chk("out_drop", 32'(out_valid), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("ce_count", m_k, n);
        chk("result_model", got, sum);
        if (exp_rise >= 0) chk("rise_cycle", rise, exp_rise);
        if (n == 0) chk("no_in_ready", nrdy, 0);
    endtask

    initial begin
        logic [31:0] got;
        rst       = 1'b1;
        start     = 1'b0;
        len       = '0;
        init      = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        spur      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_add_ce", 32'(add_ce), 32'd0);
        chk("rst_add_op", 32'(add_op), 32'd1);
        chk("rst_add_a", add_a, 32'd0);
        chk("rst_add_b", add_b, 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 4; i++) m_terms[i] = 32'(i + 1);
        reduce(32'd0, 4, 0, 0, 13, -1, 1'b0, got);
        chk("basic_sum", got, 32'd10);

        reduce(32'h55, 0, 0, 0, 1, -1, 1'b0, got);
        chk("zero_len", got, 32'h55);

        m_terms[0] = 32'd1;
        m_terms[1] = 32'hFFFF_FFFD;
        reduce(32'h7FFF_FFFF, 2, 0, 0, 7, -1, 1'b0, got);
        chk("wrap_sum", got, 32'h7FFF_FFFD);
        chk("wrap_mid_add_a", ce_a[1], 32'h8000_0000);

        m_terms[0] = 32'd5;
        m_terms[1] = 32'd6;
        m_terms[2] = 32'd7;
        reduce(32'd0, 3, 2, 5, 16, -1, 1'b0, got);
        chk("backpressure_sum", got, 32'd18);

        m_terms[0] = 32'd4;
        m_terms[1] = 32'd9;
        reduce(32'd1, 2, 2, 0, 11, 2, 1'b0, got);
        chk("ignored_start", got, 32'd14);

        m_terms[0] = 32'd10;
        m_terms[1] = 32'd20;
        m_terms[2] = 32'd30;
        reduce(32'd100, 3, 1, 1, 13, -1, 1'b1, got);
        chk("spurious_done", got, 32'd160);

        // abort a len=3 reduction in its second WAIT
        m_terms[0] = 32'd1;
        m_terms[1] = 32'd2;
        m_terms[2] = 32'd3;
        m_init     = 32'h11;
        m_final    = 32'h17;
        m_len      = 3;
        m_epoch++;
        start    = 1'b1;
        len      = 8'd3;
        init     = 32'h11;
        in_valid = 1'b1;
        in_data  = m_terms[0];
        for (int c = 1; c <= 7; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) start = 1'b0;
            if (c == 2) in_data = m_terms[1];
            if (c == 5) in_data = m_terms[2];
            if (c == 6) begin
                chk("pre_rst_add_a", add_a, 32'h12);
                rst = 1'b1;
            end
            if (c == 7) begin
                chk("abort_busy", 32'(busy), 32'd0);
                chk("abort_out_valid", 32'(out_valid), 32'd0);
                chk("abort_in_ready", 32'(in_ready), 32'd0);
                chk("abort_add_a", add_a, 32'd0);
                rst      = 1'b0;
                in_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        m_terms[0] = 32'd3;
        reduce(32'd2, 1, 0, 0, 4, -1, 1'b0, got);
        chk("after_reset", got, 32'd5);

        for (int i = 0; i < 255; i++) m_terms[i] = $urandom;
        reduce($urandom, 255, 0, 0, 766, -1, 1'b0, got);

        for (int r = 0; r < 25; r++) begin
            int n;
            n = int'($urandom_range(0, 8));
            for (int i = 0; i < n; i++) m_terms[i] = $urandom;
            reduce($urandom, n, -1, -1, -1, -1, 1'($urandom_range(0, 1)), got);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/int_acc_seq.md
# int_acc_seq

Sequential integer accumulator controller that sits directly upstream of the 32-bit integer adder wrapper and also consumes its result. It takes a start command with a term count and an initial value, pulls 32-bit terms over a valid/ready stream, and issues one adder operation per term. It captures each adder result into a running sum and presents the final sum on a valid/ready output. Typical use is the reduction step of an RNN matrix-vector product, where products arrive from the multiplier stage.

## Interface
- LEN_W, 8: width of the term-count input; max terms per reduction = 2^LEN_W − 1.
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a reduction; sampled only in IDLE.
- len  in  LEN_W  number of terms; sampled with start.
- init  in  32  initial accumulator value; sampled with start.
- in_valid  in  1  term available.
- in_ready  out  1  block accepts term; high only in FETCH.
- in_data  in  32  term, two's complement.
- add_a  out  32  adder operand A, the running sum.
- add_b  out  32  adder operand B, the captured term.
- add_op  out  1  adder ADD select; constant 1.
- add_ce  out  1  adder clock-enable; one-cycle pulse per term.
- add_dout  in  32  adder result.
- add_done  in  1  adder completion; high one cycle after add_ce.
- out_valid  out  1  final sum valid.
- out_ready  in  1  consumer accepts sum.
- out_data  out  32  final sum.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, FETCH, ADD, WAIT, OUT.
- IDLE:
  - On start, latch len into cnt_target, load acc←init, clear cnt.
  - If len=0, go to OUT; otherwise go to FETCH.
- FETCH: in_ready=1. On in_valid, latch term←in_data and go to ADD.
- ADD: add_ce=1 for exactly one cycle, then go to WAIT.
- WAIT:
  - On add_done=1: acc←add_dout and cnt←cnt+1.
  - Go to OUT if cnt+1=cnt_target, else to FETCH.
  - With add_done=0, remain in WAIT indefinitely; there is no timeout.
- OUT: out_valid=1 and out_data=acc, both held stable until out_ready. On handshake, go to IDLE.
- Adder operands: add_a=acc and add_b=term are registered. They are stable from ADD through WAIT, so combinational add_dout is valid when add_done arrives.
- Arithmetic: modulo 2^32 two's complement; overflow wraps silently, with no saturation or flag.
- add_done outside WAIT is ignored.
- start outside IDLE is ignored, and so are len and init.
- in_data is never consumed outside FETCH.

## Timing
- Reset values: state=IDLE, in_ready=0, add_ce=0, add_op=1, add_a=0, add_b=0, out_valid=0, out_data=0, busy=0, acc=0, cnt=0.
- Reset mid-operation aborts the reduction at the next edge. In-flight terms and results are discarded, and a pending out_valid drops.
- The clock edge that samples start in IDLE puts the block in FETCH (or OUT when len=0) on the next cycle.
- Each term takes 3 cycles minimum: FETCH, ADD, WAIT. The adder's fixed done latency is 1.
- With start at cycle 0 and continuous in_valid, out_valid first rises at cycle 1+3·len. For len=0, that is cycle 1.
- Input backpressure: each cycle of in_valid=0 in FETCH adds one cycle.
- Output backpressure: out_valid and out_data stay constant while out_ready=0.
- out_valid deasserts the cycle after the out handshake. The next start can be sampled in that IDLE cycle at the earliest, so there are no back-to-back reductions without one IDLE cycle.
- add_ce is never high in two consecutive cycles.
- Throughput is at most 1 term per 3 cycles.

## Test plan
- Basic sum: init=0, len=4, terms 1, 2, 3, 4 with in_valid always high and out_ready=1 → out_data=10, out_valid rises at cycle 13, add_ce pulses exactly 4 times.
- Zero length: len=0, init=0x0000_0055 → out_valid at cycle 1 with out_data=0x55, no in_ready and no add_ce.
- Signed and wrap:
  - init=0x7FFF_FFFF, len=2, terms 1 and −3 (0xFFFF_FFFD) → out_data=0x7FFF_FFFD.
  - The intermediate sum 0x8000_0000 is observed on add_a during the second ADD.
- Backpressure:
  - Stimulus: len=3, terms 5, 6, 7. in_valid low for 2 cycles before each term, and out_ready held low for 5 cycles.
  - Response: out_data=18 and stays stable while out_ready is low, with no extra add_ce pulses.
- Ignored events:
  - start pulsed during FETCH of a len=2 reduction → no effect, and the result equals the undisturbed sum.
  - Spurious add_done in FETCH → acc unchanged.
- Reset mid-operation: rst asserted during WAIT of a len=3 reduction → the next cycle shows IDLE, busy=0, out_valid=0 and add_a=0. A fresh len=1, init=2, term=3 then yields 5.
